// File: rtl/jpeg_ecs_bit_unpacker.sv
// JPEG entropy-coded-segment reader: strips 0xFF00 stuffing, skips 0xFF fill, traps markers,
// and presents an MSB-aligned bit window to a Huffman/VLC decoder that consumes bits per cycle.
module jpeg_ecs_bit_unpacker #(
  parameter int unsigned BUF_W    = 64,
  parameter int unsigned WIN_W    = 32,
  parameter int unsigned MAX_CONS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [WIN_W-1:0] win_data,
  output logic [5:0]       win_bits,
  input  logic             cons_valid,
  input  logic [4:0]       cons_len,
  output logic             marker_valid,
  output logic [7:0]       marker_code,
  input  logic             marker_ack,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {StData, StFf, StMark} state_e;

  state_e           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             marker_valid_q, marker_valid_d;
  logic [7:0]       marker_code_q, marker_code_d;
  logic             err_q, err_d;

  logic             accept;
  logic             append;
  logic [7:0]       app_byte;
  logic [5:0]       cons_len_ext;
  logic             cons_ok;
  logic             cons_bad;
  logic [CNT_W-1:0] cons_amt;
  logic [CNT_W-1:0] count_rem;
  logic [BUF_W-1:0] buf_shift;
  logic [BUF_W-1:0] app_vec;
  logic             flush;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StData;
      buf_q          <= '0;
      count_q        <= '0;
      marker_valid_q <= 1'b0;
      marker_code_q  <= 8'h00;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      buf_q          <= buf_d;
      count_q        <= count_d;
      marker_valid_q <= marker_valid_d;
      marker_code_q  <= marker_code_d;
      err_q          <= err_d;
    end
  end

  assign accept = in_valid && in_ready;
  assign flush  = (state_q == StMark) && marker_ack;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StData: begin
        if (accept && in_data == 8'hFF) state_d = StFf;
      end
      StFf: begin
        if (accept) begin
          if (in_data == 8'h00)      state_d = StData;
          else if (in_data != 8'hFF) state_d = StMark;
        end
      end
      StMark: begin
        if (marker_ack) state_d = StData;
      end
      default: state_d = StData;
    endcase
  end

  // Bits above count are always zero, so the window needs no masking and
  // an append is a plain OR at the first free position.
  always_comb begin
    cons_len_ext = {1'b0, cons_len};
    cons_ok      = cons_valid && (cons_len != 5'd0) && (cons_len_ext <= win_bits);
    cons_bad     = cons_valid && (cons_len_ext > win_bits);
    cons_amt     = cons_ok ? CNT_W'(cons_len) : '0;
    count_rem    = count_q - cons_amt;
    buf_shift    = buf_q << cons_amt;

    append   = accept && (((state_q == StData) && (in_data != 8'hFF)) ||
                          ((state_q == StFf) && (in_data == 8'h00)));
    app_byte = (state_q == StFf) ? 8'hFF : in_data;
    app_vec  = append ? ({app_byte, {(BUF_W-8){1'b0}}} >> count_rem) : '0;

    buf_d   = buf_shift | app_vec;
    count_d = count_rem + (append ? CNT_W'(8) : '0);
    if (flush) begin
      buf_d   = '0;
      count_d = '0;
    end

    marker_valid_d = marker_valid_q;
    marker_code_d  = marker_code_q;
    if ((state_q == StFf) && accept && (in_data != 8'h00) && (in_data != 8'hFF)) begin
      marker_valid_d = 1'b1;
      marker_code_d  = in_data;
    end
    if (flush) marker_valid_d = 1'b0;

    err_d = err_q | cons_bad;
  end

  // Outputs: everything derives from registered state (rst_n only gates in_ready low in reset).
  always_comb begin
    in_ready     = rst_n && (state_q != StMark) && (count_q <= CNT_W'(BUF_W - 8));
    win_data     = buf_q[BUF_W-1 -: WIN_W];
    win_bits     = (count_q >= CNT_W'(WIN_W)) ? 6'(WIN_W) : 6'(count_q);
    marker_valid = marker_valid_q;
    marker_code  = marker_code_q;
    err          = err_q;
  end

endmodule

// File: tb/tb_jpeg_ecs_bit_unpacker.sv
// Self-checking bench for jpeg_ecs_bit_unpacker: a bit-queue scoreboard models the unread
// stream; directed tests follow the intended behaviour, then a randomised back-to-back run.
module tb_jpeg_ecs_bit_unpacker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic [31:0] win_data;
  logic [5:0]  win_bits;
  logic        cons_valid = 1'b0;
  logic [4:0]  cons_len = 5'd0;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        marker_ack = 1'b0;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: unread stream bits, oldest first, plus a small parser model.
  bit       exp_bits[$];
  int       m_state = 0;  // 0 data, 1 after 0xFF, 2 marker held
  bit       m_mv    = 1'b0;
  bit [7:0] m_code  = 8'h00;
  bit       m_err   = 1'b0;

  jpeg_ecs_bit_unpacker #(.BUF_W(64), .WIN_W(32), .MAX_CONS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .win_data     (win_data),
    .win_bits     (win_bits),
    .cons_valid   (cons_valid),
    .cons_len     (cons_len),
    .marker_valid (marker_valid),
    .marker_code  (marker_code),
    .marker_ack   (marker_ack),
    .err          (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_win();
    logic [31:0] w = 32'h0;
    for (int i = 0; i < 32 && i < exp_bits.size(); i++) w[31-i] = exp_bits[i];
    return w;
  endfunction

  function automatic logic [5:0] exp_wb();
    return (exp_bits.size() > 32) ? 6'd32 : 6'(exp_bits.size());
  endfunction

  function automatic bit exp_rdy();
    return (m_state != 2) && (exp_bits.size() <= 56);
  endfunction

  // Drive one cycle of stimulus, update the model, and return 1 cycle later (#1 after edge).
  task automatic step(input bit v, input logic [7:0] d, input bit cv, input logic [4:0] cl,
                      input bit ack, output bit acc);
    int wb;
    wb  = (exp_bits.size() > 32) ? 32 : exp_bits.size();
    acc = v && exp_rdy();
    in_valid = v; in_data = d; cons_valid = cv; cons_len = cl; marker_ack = ack;
    if (cv && cl != 0 && int'(cl) <= wb) begin
      for (int i = 0; i < int'(cl); i++) void'(exp_bits.pop_front());
    end else if (cv && int'(cl) > wb) begin
      m_err = 1'b1;
    end
    if (m_state == 2 && ack) begin
      exp_bits.delete();
      m_mv    = 1'b0;
      m_state = 0;
    end else if (acc && m_state == 0) begin
      if (d == 8'hFF) m_state = 1;
      else for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
    end else if (acc && m_state == 1) begin
      if (d == 8'h00) begin
        for (int i = 0; i < 8; i++) exp_bits.push_back(1'b1);
        m_state = 0;
      end else if (d != 8'hFF) begin
        m_mv    = 1'b1;
        m_code  = d;
        m_state = 2;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; cons_valid = 1'b0; cons_len = 5'd0; marker_ack = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    bit a;
    step(1'b1, d, 1'b0, 5'd0, 1'b0, a);
  endtask

  task automatic consume(input logic [4:0] cl);
    bit a;
    step(1'b0, 8'h00, 1'b1, cl, 1'b0, a);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || win_bits !== 6'd0 || win_data !== 32'h0 ||
        marker_valid !== 1'b0 || marker_code !== 8'h00 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b bits=%0d data=%h mv=%b code=%h err=%b want all 0",
               in_ready, win_bits, win_data, marker_valid, marker_code, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_append();
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    n_checks++;
    if (win_data !== 32'h12345678 || win_bits !== 6'd32) begin
      n_fail++;
      $display("FAIL t1_window: got %h/%0d want 12345678/32", win_data, win_bits);
    end
    send(8'h9A); send(8'hBC); send(8'hDE);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_ready_at_56: got %b want 1", in_ready);
    end
    send(8'hF0);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_ready_at_64: got %b want 0", in_ready);
    end
    send(8'h11);  // refused: buffer full
    for (int k = 0; k < 4; k++) begin
      consume(5'd16);
      n_checks++;
      if (win_data !== exp_win() || win_bits !== exp_wb()) begin
        n_fail++;
        $display("FAIL t1_drain%0d: got %h/%0d want %h/%0d", k, win_data, win_bits,
                 exp_win(), exp_wb());
      end
    end
    n_checks++;
    if (win_bits !== 6'd0) begin
      n_fail++;
      $display("FAIL t1_empty: got %0d want 0", win_bits);
    end
  endtask

  task automatic test_stuffing();
    send(8'hFF);
    n_checks++;
    if (win_bits !== 6'd0) begin
      n_fail++;
      $display("FAIL t2_ff_pending: got %0d want 0", win_bits);
    end
    send(8'h00);
    n_checks++;
    if (win_data !== 32'hFF000000 || win_bits !== 6'd8) begin
      n_fail++;
      $display("FAIL t2_stuffed: got %h/%0d want ff000000/8", win_data, win_bits);
    end
    send(8'hAB);
    n_checks++;
    if (win_data[31:16] !== 16'hFFAB || win_bits !== 6'd16 || marker_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_window: got %h/%0d mv=%b want ffab/16 mv=0", win_data[31:16], win_bits,
               marker_valid);
    end
    consume(5'd16);
  endtask

  task automatic test_marker();
    bit a;
    send(8'hAA); send(8'hFF); send(8'hFF); send(8'hFF); send(8'hD3);
    n_checks++;
    if (win_bits !== 6'd8 || marker_valid !== 1'b1 || marker_code !== 8'hD3 ||
        in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_marker: got bits=%0d mv=%b code=%h rdy=%b want 8/1/d3/0",
               win_bits, marker_valid, marker_code, in_ready);
    end
    send(8'h77);  // stalled
    consume(5'd4);
    n_checks++;
    if (win_data !== exp_win() || win_bits !== 6'd4) begin
      n_fail++;
      $display("FAIL t3_consume_in_mark: got %h/%0d want %h/4", win_data, win_bits, exp_win());
    end
    step(1'b0, 8'h00, 1'b1, 5'd2, 1'b1, a);  // flush wins over consume
    n_checks++;
    if (win_bits !== 6'd0 || marker_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_ack: got bits=%0d mv=%b rdy=%b want 0/0/1", win_bits, marker_valid,
               in_ready);
    end
    send(8'h5A);
    n_checks++;
    if (win_data !== 32'h5A000000 || win_bits !== 6'd8) begin
      n_fail++;
      $display("FAIL t3_after_ack: got %h/%0d want 5a000000/8", win_data, win_bits);
    end
    step(1'b0, 8'h00, 1'b0, 5'd0, 1'b1, a);  // stray ack ignored
    n_checks++;
    if (win_bits !== 6'd8 || marker_code !== 8'hD3) begin
      n_fail++;
      $display("FAIL t3_stray_ack: got %0d/%h want 8/d3", win_bits, marker_code);
    end
    consume(5'd8);
  endtask

  task automatic test_consume_append();
    bit a;
    send(8'hF0); send(8'h11); send(8'h22); send(8'h33);
    step(1'b1, 8'h9C, 1'b1, 5'd4, 1'b0, a);
    n_checks++;
    if (win_data !== 32'h01122339 || win_bits !== 6'd32 || exp_bits.size() != 36) begin
      n_fail++;
      $display("FAIL t4_same_cycle: got %h/%0d want 01122339/32", win_data, win_bits);
    end
    consume(5'd16);
    n_checks++;
    if (win_data !== 32'h2339C000 || win_bits !== 6'd20) begin
      n_fail++;
      $display("FAIL t4_tail: got %h/%0d want 2339c000/20", win_data, win_bits);
    end
    consume(5'd16); consume(5'd4);
  endtask

  task automatic test_overconsume();
    send(8'hA7);
    consume(5'd5);
    consume(5'd5);
    n_checks++;
    if (err !== 1'b1 || win_bits !== 6'd3 || win_data !== 32'hE0000000) begin
      n_fail++;
      $display("FAIL t5_overconsume: got err=%b %h/%0d want 1 e0000000/3", err, win_data,
               win_bits);
    end
    consume(5'd0);
    n_checks++;
    if (win_bits !== 6'd3) begin
      n_fail++;
      $display("FAIL t5_zero_len: got %0d want 3", win_bits);
    end
    consume(5'd3);
    n_checks++;
    if (win_bits !== 6'd0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_sticky: got bits=%0d err=%b want 0/1", win_bits, err);
    end
  endtask

  task automatic test_back_to_back();
    bit          a;
    bit          v;
    bit          cv;
    logic [7:0]  d;
    logic [4:0]  cl;
    for (int k = 0; k < 300; k++) begin
      v  = ($urandom_range(0, 3) != 0);
      cv = ($urandom_range(0, 1) != 0);
      cl = 5'($urandom_range(0, 16));
      if (m_state == 1) d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'h00;
      else d = 8'($urandom_range(0, 255));
      step(v, d, cv, cl, 1'b0, a);
      n_checks++;
      if (win_data !== exp_win() || win_bits !== exp_wb() || in_ready !== exp_rdy() ||
          marker_valid !== 1'b0 || err !== m_err) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h/%0d rdy=%b mv=%b err=%b want %h/%0d rdy=%b mv=0 err=%b",
                 k, win_data, win_bits, in_ready, marker_valid, err, exp_win(), exp_wb(),
                 exp_rdy(), m_err);
      end
    end
    while (exp_bits.size() > 0) consume(5'((exp_bits.size() > 16) ? 16 : exp_bits.size()));
    if (m_state == 1) send(8'h00);
    while (exp_bits.size() > 0) consume(5'((exp_bits.size() > 16) ? 16 : exp_bits.size()));
  endtask

  task automatic test_async_reset();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    send(8'hFF); send(8'hD9);
    n_checks++;
    if (marker_valid !== 1'b1 || marker_code !== 8'hD9 || win_bits !== 6'd32 || err !== 1'b1 ||
        exp_bits.size() != 40) begin
      n_fail++;
      $display("FAIL t6_setup: got mv=%b code=%h bits=%0d err=%b want 1/d9/32/1",
               marker_valid, marker_code, win_bits, err);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || win_bits !== 6'd0 || win_data !== 32'h0 ||
        marker_valid !== 1'b0 || marker_code !== 8'h00 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_async_clear: got rdy=%b bits=%0d data=%h mv=%b code=%h err=%b want 0s",
               in_ready, win_bits, win_data, marker_valid, marker_code, err);
    end
    exp_bits.delete(); m_state = 0; m_mv = 1'b0; m_code = 8'h00; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || marker_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_release: got rdy=%b mv=%b err=%b want 1/0/0", in_ready, marker_valid,
               err);
    end
    @(posedge clk);
    #1;
    send(8'h3C);
    n_checks++;
    if (win_data !== 32'h3C000000 || win_bits !== 6'd8) begin
      n_fail++;
      $display("FAIL t6_post_reset: got %h/%0d want 3c000000/8", win_data, win_bits);
    end
  endtask

  initial begin
    test_reset();
    test_append();
    test_stuffing();
    test_marker();
    test_consume_append();
    test_overconsume();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
